// File: rtl/led_flow_engine.sv
// led_flow_engine: parametrised LED flow-pattern generator.
//
// A single prescaler counts CLK_In cycles and produces a step tick every
// DIVsel clocks. DIVsel is chosen by the registered speed. One shared pattern
// engine advances on each tick and supports four modes: forward, reverse,
// ping-pong and bar-fill. There are no derived clocks.
//
// Ports:
//   CLK_In   in   1      system clock, the only clock
//   RST      in   1      synchronous active-high reset
//   Mode     in   2      0 forward, 1 reverse, 2 ping-pong, 3 bar-fill
//   Speed    in   2      selects DIV0..DIV3
//   Pause    in   1      freezes prescaler and pattern while high
//   LED_Out  out  LED_W  registered LED drive
//   Step     out  1      one-cycle pulse coincident with each pattern advance
//
// Configuration macro: LED_ACTIVE_LOW_EN. When it is defined, LED_Out is the
// bitwise inverse of every pattern; Step is unaffected.

module led_flow_engine #(
   parameter int unsigned LED_W = 3,
   parameter int unsigned DIV0  = 6000000,
   parameter int unsigned DIV1  = 2400000,
   parameter int unsigned DIV2  = 1090909,
   parameter int unsigned DIV3  = 12000000,
   parameter int unsigned CNT_W = 24
) (
   input  logic             CLK_In,
   input  logic             RST,
   input  logic [1:0]       Mode,
   input  logic [1:0]       Speed,
   input  logic             Pause,
   output logic [LED_W-1:0] LED_Out,
   output logic             Step
);

   localparam int unsigned POS_W = $clog2(LED_W + 1);

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [LED_W-1:0] led_t;

   // Ping-pong uses these as UP/DOWN; bar-fill reuses them as FILL/EMPTY.
   typedef enum logic {StUp = 1'b0, StDown = 1'b1} dir_e;

   localparam pos_t LastPos = pos_t'(LED_W - 1);
   localparam cnt_t Div0M1  = cnt_t'(DIV0 - 1);
   localparam cnt_t Div1M1  = cnt_t'(DIV1 - 1);
   localparam cnt_t Div2M1  = cnt_t'(DIV2 - 1);
   localparam cnt_t Div3M1  = cnt_t'(DIV3 - 1);

   function automatic led_t one_hot(input pos_t p);
      led_t v;
      for (int i = 0; i < int'(LED_W); i++) begin
         v[i] = (pos_t'(i) == p);
      end
      return v;
   endfunction

   // Low p+1 bits set.
   function automatic led_t bar(input pos_t p);
      led_t v;
      for (int i = 0; i < int'(LED_W); i++) begin
         v[i] = (pos_t'(i) <= p);
      end
      return v;
   endfunction

   function automatic led_t polarize(input led_t pat);
`ifdef LED_ACTIVE_LOW_EN
      return ~pat;
`else
      return pat;
`endif
   endfunction

   cnt_t       cnt_q, cnt_d;
   pos_t       pos_q, pos_d;
   dir_e       dir_q, dir_d;
   logic [1:0] mode_q, mode_d;
   logic [1:0] speed_q, speed_d;
   led_t       led_q, led_d;
   logic       step_q, step_d;

   cnt_t       div_m1;
   logic       tick;
   led_t       pat;

   always_comb begin
      unique case (speed_q)
         2'd0:    div_m1 = Div0M1;
         2'd1:    div_m1 = Div1M1;
         2'd2:    div_m1 = Div2M1;
         default: div_m1 = Div3M1;
      endcase
   end

   assign tick = (cnt_q == div_m1);

   always_comb begin
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      speed_d = speed_q;
      led_d   = led_q;
      step_d  = 1'b0;
      pat     = '0;

      if (Mode != mode_q) begin
         // Mode change wins over pause, speed change and tick.
         mode_d  = Mode;
         speed_d = Speed;
         cnt_d   = '0;
         pos_d   = '0;
         dir_d   = StUp;
         led_d   = polarize(led_t'(1));
      end else if (!Pause) begin
         // Speed is only adopted while running so cnt never outruns DIVsel.
         if (Speed != speed_q) begin
            speed_d = Speed;
            cnt_d   = '0;
         end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            unique case (mode_q)
               2'd0: begin
                  pos_d = (pos_q == LastPos) ? '0 : pos_q + pos_t'(1);
                  pat   = one_hot(pos_d);
               end
               2'd1: begin
                  pos_d = (pos_q == '0) ? LastPos : pos_q - pos_t'(1);
                  pat   = one_hot(pos_d);
               end
               2'd2: begin
                  if (dir_q == StUp) begin
                     pos_d = pos_q + pos_t'(1);
                     if (pos_d == LastPos) dir_d = StDown;
                  end else begin
                     pos_d = pos_q - pos_t'(1);
                     if (pos_d == '0) dir_d = StUp;
                  end
                  pat = one_hot(pos_d);
               end
               default: begin
                  if (dir_q == StDown) begin
                     pos_d = '0;
                     dir_d = StUp;
                     pat   = bar('0);
                  end else if (pos_q == LastPos) begin
                     dir_d = StDown;
                     pat   = '0;
                  end else begin
                     pos_d = pos_q + pos_t'(1);
                     pat   = bar(pos_d);
                  end
               end
            endcase
            led_d = polarize(pat);
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge CLK_In) begin
      if (RST) begin
         cnt_q   <= '0;
         pos_q   <= '0;
         dir_q   <= StUp;
         mode_q  <= Mode;
         speed_q <= Speed;
         led_q   <= polarize(led_t'(1));
         step_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         speed_q <= speed_d;
         led_q   <= led_d;
         step_q  <= step_d;
      end
   end

   assign LED_Out = led_q;
   assign Step    = step_q;

endmodule

// File: tb/tb_led_flow_engine.sv
// Directed testbench for led_flow_engine with LED_W=4 and small dividers.
// Expected patterns are written active-high and converted to drive polarity
// by pol(), so the bench works with or without LED_ACTIVE_LOW_EN.

module tb_led_flow_engine;

   localparam int unsigned LED_W = 4;

   logic             clk;
   logic             rst;
   logic [1:0]       mode;
   logic [1:0]       speed;
   logic             pause;
   logic [LED_W-1:0] led;
   logic             step;

   int checks = 0;
   int errors = 0;
   logic [3:0] cur;  // current expected active-high pattern

   led_flow_engine #(
      .LED_W (LED_W),
      .DIV0  (4),
      .DIV1  (3),
      .DIV2  (5),
      .DIV3  (6),
      .CNT_W (4)
   ) u_dut (
      .CLK_In  (clk),
      .RST     (rst),
      .Mode    (mode),
      .Speed   (speed),
      .Pause   (pause),
      .LED_Out (led),
      .Step    (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] pol(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock, then sample away from the edge.
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Hold for div-1 clocks without a step, then step to pattern nxt.
   task automatic expect_step(input int div, input logic [3:0] nxt);
      for (int i = 0; i < div - 1; i++) begin
         clk1();
         check("hold_step", 16'(step), 16'd0);
         check("hold_led", 16'(led), 16'(pol(cur)));
      end
      clk1();
      check("step_pulse", 16'(step), 16'd1);
      check("step_led", 16'(led), 16'(pol(nxt)));
      cur = nxt;
   endtask

   // Apply a mode change and check the immediate restart to bit 0.
   task automatic change_mode(input logic [1:0] m);
      mode = m;
      clk1();
      check("mode_led", 16'(led), 16'(pol(4'b0001)));
      check("mode_step", 16'(step), 16'd0);
      cur = 4'b0001;
   endtask

   logic [3:0] fwd [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] png [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
   logic [3:0] barf [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};

   initial begin
      rst   = 1'b1;
      mode  = 2'd0;
      speed = 2'd0;
      pause = 1'b0;
      clk1();
      check("rst_led", 16'(led), 16'(pol(4'b0001)));
      check("rst_step", 16'(step), 16'd0);
      cur = 4'b0001;
      rst = 1'b0;

      // Forward, DIV0=4.
      foreach (fwd[i]) expect_step(4, fwd[i]);

      // Ping-pong: no double dwell at the ends; ends in DOWN at 0100.
      change_mode(2'd2);
      foreach (png[i]) expect_step(4, png[i]);

      // Reset mid-pattern while DOWN: restarts at bit 0 going up.
      rst = 1'b1;
      clk1();
      check("rst2_led", 16'(led), 16'(pol(4'b0001)));
      check("rst2_step", 16'(step), 16'd0);
      cur = 4'b0001;
      rst = 1'b0;
      expect_step(4, 4'b0010);
      expect_step(4, 4'b0100);

      // Bar-fill.
      change_mode(2'd3);
      foreach (barf[i]) expect_step(4, barf[i]);

      // Reverse wraps 0 -> LED_W-1.
      change_mode(2'd1);
      expect_step(4, 4'b1000);
      expect_step(4, 4'b0100);

      // Mode change on the same edge as a tick: tick discarded.
      repeat (3) clk1();
      change_mode(2'd0);
      expect_step(4, 4'b0010);

      // Pause with cnt=2, then step 2 clocks after release.
      repeat (2) clk1();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clk1();
         check("pause_step", 16'(step), 16'd0);
      end
      check("pause_led", 16'(led), 16'(pol(4'b0010)));
      pause = 1'b0;
      clk1();
      check("unpause_nostep", 16'(step), 16'd0);
      clk1();
      check("unpause_step", 16'(step), 16'd1);
      check("unpause_led", 16'(led), 16'(pol(4'b0100)));
      cur = 4'b0100;

      // Speed change: restarts prescaler, no step, pattern unchanged.
      speed = 2'd1;
      clk1();
      check("spd_step", 16'(step), 16'd0);
      check("spd_led", 16'(led), 16'(pol(4'b0100)));
      expect_step(3, 4'b1000);
      expect_step(3, 4'b0001);
      speed = 2'd3;
      clk1();
      check("spd3_step", 16'(step), 16'd0);
      expect_step(6, 4'b0010);

      // Mode change applies while paused; pattern then stays frozen.
      pause = 1'b1;
      change_mode(2'd2);
      for (int i = 0; i < 8; i++) begin
         clk1();
         check("pmode_step", 16'(step), 16'd0);
      end
      check("pmode_led", 16'(led), 16'(pol(4'b0001)));
      pause = 1'b0;
      expect_step(6, 4'b0010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule

// File: doc/led_flow_engine.md
# led_flow_engine

Parametrised LED flow-pattern generator; successor to the fixed 3-LED, 3-speed flow-light top. One prescaler driven from `CLK_In` produces step enables. There are no derived clocks. A single pattern engine is shared by four modes: forward, reverse, ping-pong and bar-fill. It drives `LED_Out` directly and sits between the board switches and the LED pins.

## Interface
- `LED_W`, 3: number of LEDs; legal range 2..16.
- `DIV0`, 6000000: clocks per step at `Speed`=0 (2 Hz at 12 MHz).
- `DIV1`, 2400000: clocks per step at `Speed`=1 (5 Hz).
- `DIV2`, 1090909: clocks per step at `Speed`=2 (11 Hz).
- `DIV3`, 12000000: clocks per step at `Speed`=3 (1 Hz).
- `CNT_W`, 24: prescaler width; must hold max(DIVn)-1.
- `CLK_In`  in  1  system clock; the only clock.
- `RST`  in  1  reset; synchronous, active-high.
- `Mode`  in  2  0 forward, 1 reverse, 2 ping-pong, 3 bar-fill.
- `Speed`  in  2  selects DIV0..DIV3.
- `Pause`  in  1  freezes prescaler and pattern while high.
- `LED_Out`  out  LED_W  LED drive; registered.
- `Step`  out  1  one-cycle pulse coincident with each pattern advance.

## Operation
- **State:**
  - prescaler `cnt` (CNT_W bits);
  - position/level `pos` (clog2(LED_W+1) bits);
  - direction `dir` (0 = up);
  - registered copies `mode_q` and `speed_q`.
- **Reset** (`RST`=1 at an edge):
  - `cnt`=0, `pos`=0 (fill level 1), `dir`=0;
  - `mode_q`/`speed_q` load the current inputs;
  - `LED_Out`=1 (bit 0 lit), `Step`=0.
- **Prescaler:**
  - if `cnt`==DIVsel-1, tick=1 and `cnt` goes to 0;
  - otherwise `cnt`+1;
  - DIVsel is taken from `speed_q`.
- **Speed change** (`Speed`!=`speed_q`): `cnt` goes to 0 and `speed_q` updates. There is no tick that cycle. Pattern and `LED_Out` are unchanged.
- **Mode change** (`Mode`!=`mode_q`):
  - `mode_q` updates; `cnt`, `pos` and `dir` return to reset values;
  - `LED_Out`=1, no `Step`;
  - applies even while `Pause`=1;
  - mode change has priority over a same-cycle tick or speed change. Both registers update; the tick is discarded.
- **Pause:** `cnt`, `pos`, `dir` and `LED_Out` hold; `Step`=0.
- **Step rules** on tick:
  - **Forward:** `pos`+1; LED_W-1 wraps to 0. `LED_Out` = one-hot at `pos`.
  - **Reverse:** `pos`-1; 0 wraps to LED_W-1.
  - **Ping-pong:** two-state FSM, UP/DOWN held in `dir`.
    - UP: `pos`+1; on reaching LED_W-1, go to DOWN.
    - DOWN: `pos`-1; on reaching 0, go to UP.
    - End LEDs are lit for one step only (no double dwell).
  - **Bar-fill:** two-state FSM, FILL/EMPTY.
    - FILL: `LED_Out` = low `pos`+1 bits set. Level increments up to all-ones (LED_W lit). The next tick goes to EMPTY with `LED_Out`=0.
    - EMPTY: the next tick goes to FILL at level 1.
- `LED_Out` is always fully registered; no combinational path from inputs to outputs.

## Timing
- `LED_Out` and `Step` update on the same edge where tick is detected (`cnt`==DIVsel-1). Step period is exactly DIVsel clocks.
- First step after reset or mode change: DIVsel clocks later.
- Latency from a `Pause` fall to the next step: DIVsel-`cnt` clocks. Pause is non-destructive to prescaler phase.
- `Mode`, `Speed` and `Pause` are sampled every edge. The integrating top synchronises switch inputs before connecting them.

## Configuration
- **`LED_ACTIVE_LOW_EN` defined:** `LED_Out` is the bitwise inverse of every pattern above.
  - Reset value is ~1: all ones except bit 0 low.
  - Bar-fill EMPTY is all ones.
- **Undefined:** active-high as described.
- `Step` polarity is unaffected by the macro.

## Test plan
- LED_W=4, DIV0=4, Mode=0, Speed=0, release reset → `LED_Out`: 0001, 0010, 0100, 1000, 0001. Changes every 4 clocks with `Step` high one cycle each.
- Mode=2 from reset, DIV0=4 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. No repeated end value.
- Mode=3 from reset → 0001, 0011, 0111, 1111, 0000, 0001.
- Mode=1 at `LED_Out`=0100, switch to Mode=0 on the same cycle as a tick → next edge `LED_Out`=0001, `Step`=0; next step 4 clocks later gives 0010.
- `Pause` high for 10 clocks with `cnt`=2 → no change, `Step`=0. Step occurs 2 clocks after `Pause` falls. Repeat with `LED_ACTIVE_LOW_EN`: reset value 1110.
- `RST` pulsed mid-pattern (Mode=2, DOWN) → next edge `LED_Out`=0001, `dir`=UP. First step after 4 clocks gives 0010.
